// File: rtl/fp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : fp_pkg
// Brief  : Shared encodings and field helpers for FloPoCo-format words
//          (exc[1:0], sign, exp, frac, MSB first).
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package fp_pkg;

  // Exception field encodings
  localparam logic [1:0] EXC_ZERO = 2'b00;
  localparam logic [1:0] EXC_NORM = 2'b01;
  localparam logic [1:0] EXC_INF  = 2'b10;
  localparam logic [1:0] EXC_NAN  = 2'b11;

  // Relation op codes (3'b11x reserved)
  localparam logic [2:0] OP_EQ = 3'b000;
  localparam logic [2:0] OP_NE = 3'b001;
  localparam logic [2:0] OP_LT = 3'b010;
  localparam logic [2:0] OP_LE = 3'b011;
  localparam logic [2:0] OP_GT = 3'b100;
  localparam logic [2:0] OP_GE = 3'b101;

  // Helpers work on a zero-extended container wide enough for any format
  // in use; the format widths are passed in so one set serves every width.
  localparam int FP_MAXW = 64;
  typedef logic [FP_MAXW-1:0] fp_word_t;

  function automatic logic [1:0] fp_exc(input fp_word_t w, input int we, input int wf);
    return w[we+wf+1 +: 2];
  endfunction

  function automatic logic fp_sign(input fp_word_t w, input int we, input int wf);
    return w[we+wf];
  endfunction

  // Magnitude key {exc, exp, frac}; exp/frac are forced to 0 unless the
  // word is a normal number so all zeros (and all infs) share one key.
  function automatic fp_word_t fp_key(input fp_word_t w, input int we, input int wf);
    fp_word_t mask;
    fp_word_t body;
    mask = (fp_word_t'(1) << (we + wf)) - fp_word_t'(1);
    body = w & mask;
    if (fp_exc(w, we, wf) != EXC_NORM) body = '0;
    return (fp_word_t'(fp_exc(w, we, wf)) << (we + wf)) | body;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_compare_pipe_mag_cmp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : fp_mag_cmp
// Brief  : Combinational unsigned key comparator (lt / eq). Kept separate so
//          very wide keys can later be split across an extra stage.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module fp_mag_cmp #(
  parameter int KW = 64
) (
  input  logic [KW-1:0] key_a,
  input  logic [KW-1:0] key_b,
  output logic          lt,
  output logic          eq
);

  // Plain unsigned magnitude comparison of the two keys
  always_comb begin
    lt = (key_a < key_b);
    eq = (key_a == key_b);
  end

endmodule
`default_nettype wire

// File: rtl/fp_compare_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : fp_compare_pipe
// Brief  : Two-stage pipelined FloPoCo comparator with valid/ready stream:
//          relation result, lt/eq/gt/unord flags and min/max.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module fp_compare_pipe
  import fp_pkg::*;
#(
  parameter int WE = 11,
  parameter int WF = 17,
  parameter int W  = WE + WF + 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [2:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_result,
  output logic         out_lt,
  output logic         out_eq,
  output logic         out_gt,
  output logic         out_unord,
  output logic [W-1:0] out_min,
  output logic [W-1:0] out_max
);

  // ---------------- stage 0: field decode and key compare ----------------
  fp_word_t a_ext, b_ext, key_a, key_b;
  logic [1:0] exc_a, exc_b;
  logic mag_lt, mag_eq;

  // Decode the incoming words into exception class and magnitude key
  always_comb begin
    a_ext = fp_word_t'(in_a);
    b_ext = fp_word_t'(in_b);
    exc_a = fp_exc(a_ext, WE, WF);
    exc_b = fp_exc(b_ext, WE, WF);
    key_a = fp_key(a_ext, WE, WF);
    key_b = fp_key(b_ext, WE, WF);
  end

  fp_mag_cmp #(.KW(FP_MAXW)) u_mag_cmp (
    .key_a (key_a),
    .key_b (key_b),
    .lt    (mag_lt),
    .eq    (mag_eq)
  );

  // ---------------- handshake ----------------
  logic s1_valid, s2_valid, s1_adv;

  assign s1_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s1_adv;
  assign out_valid = s2_valid;

  // ---------------- stage 1 registers ----------------
  logic         s1_sign_a, s1_sign_b, s1_both_zero, s1_unord, s1_mag_lt, s1_mag_eq;
  logic [2:0]   s1_op;
  logic [W-1:0] s1_a, s1_b;

  // Stage 1 captures decoded fields whenever a pair is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_sign_a    <= 1'b0;
      s1_sign_b    <= 1'b0;
      s1_both_zero <= 1'b0;
      s1_unord     <= 1'b0;
      s1_mag_lt    <= 1'b0;
      s1_mag_eq    <= 1'b0;
      s1_op        <= '0;
      s1_a         <= '0;
      s1_b         <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_ready && in_valid) begin
        s1_sign_a    <= fp_sign(a_ext, WE, WF);
        s1_sign_b    <= fp_sign(b_ext, WE, WF);
        s1_both_zero <= (exc_a == EXC_ZERO) && (exc_b == EXC_ZERO);
        s1_unord     <= (exc_a == EXC_NAN) || (exc_b == EXC_NAN);
        s1_mag_lt    <= mag_lt;
        s1_mag_eq    <= mag_eq;
        s1_op        <= in_op;
        s1_a         <= in_a;
        s1_b         <= in_b;
      end
    end
  end

  // ---------------- stage 2 resolve ----------------
  logic         r_lt, r_eq, r_gt, r_result;
  logic [W-1:0] r_min, r_max;

  // Combine sign, zero and magnitude information into the final relation
  always_comb begin
    r_lt = 1'b0;
    r_eq = 1'b0;
    r_gt = 1'b0;
    if (s1_unord) begin
      r_lt = 1'b0;
    end else if (s1_both_zero) begin
      r_eq = 1'b1;
    end else if (s1_sign_a != s1_sign_b) begin
      r_lt = s1_sign_a;
      r_gt = s1_sign_b;
    end else if (s1_mag_eq) begin
      r_eq = 1'b1;
    end else if (!s1_sign_a) begin
      r_lt = s1_mag_lt;
      r_gt = !s1_mag_lt;
    end else begin
      r_lt = !s1_mag_lt;
      r_gt = s1_mag_lt;
    end

    case (s1_op)
      OP_EQ:   r_result = r_eq;
      OP_NE:   r_result = !r_eq;
      OP_LT:   r_result = r_lt;
      OP_LE:   r_result = r_lt || r_eq;
      OP_GT:   r_result = r_gt;
      OP_GE:   r_result = r_gt || r_eq;
      default: r_result = 1'b0;
    endcase

    if (s1_unord) begin
      r_min = s1_a;
      r_max = s1_a;
    end else if (r_lt) begin
      r_min = s1_a;
      r_max = s1_b;
    end else begin
      r_min = s1_b;
      r_max = s1_a;
    end
  end

  // Stage 2 loads the resolved result when it is empty or being drained
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      out_result <= 1'b0;
      out_lt     <= 1'b0;
      out_eq     <= 1'b0;
      out_gt     <= 1'b0;
      out_unord  <= 1'b0;
      out_min    <= '0;
      out_max    <= '0;
    end else begin
      if (s1_adv) s2_valid <= s1_valid;
      if (s1_adv && s1_valid) begin
        out_result <= r_result;
        out_lt     <= r_lt;
        out_eq     <= r_eq;
        out_gt     <= r_gt;
        out_unord  <= s1_unord;
        out_min    <= r_min;
        out_max    <= r_max;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_compare_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// Module : tb_fp_compare_pipe
// Brief  : Self-checking bench: value-level reference model + scoreboard,
//          plus directed literal expectations.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_fp_compare_pipe;

  localparam int WE = 11;
  localparam int WF = 17;
  localparam int W  = WE + WF + 3;

  localparam logic [W-1:0] ONE   = {2'b01, 1'b0, 11'h3FF, 17'h0};
  localparam logic [W-1:0] TWO   = {2'b01, 1'b0, 11'h400, 17'h0};
  localparam logic [W-1:0] MONE  = {2'b01, 1'b1, 11'h3FF, 17'h0};
  localparam logic [W-1:0] MTWO  = {2'b01, 1'b1, 11'h400, 17'h0};
  localparam logic [W-1:0] PZERO = {2'b00, 1'b0, 11'h000, 17'h0};
  localparam logic [W-1:0] NZERO = {2'b00, 1'b1, 11'h123, 17'h5};
  localparam logic [W-1:0] PINF  = {2'b10, 1'b0, 11'h000, 17'h0};
  localparam logic [W-1:0] QNAN  = {2'b11, 1'b0, 11'h7FF, 17'h1};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [2:0]   in_op = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_result, out_lt, out_eq, out_gt, out_unord;
  logic [W-1:0] out_min, out_max;

  int checks = 0;
  int errors = 0;
  int out_count = 0;
  bit rnd_ready_en = 1'b0;

  always #5 clk = ~clk;

  fp_compare_pipe #(.WE(WE), .WF(WF)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_lt     (out_lt),
    .out_eq     (out_eq),
    .out_gt     (out_gt),
    .out_unord  (out_unord),
    .out_min    (out_min),
    .out_max    (out_max)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic         result, lt, eq, gt, unord;
    logic [W-1:0] mn, mx;
  } exp_t;

  exp_t q[$];

  // Signed numeric ordinal of a non-NaN word: zero -> 0, normals ordered by
  // value, inf beyond every normal; negation gives the negative half.
  function automatic longint ordinal(input logic [W-1:0] w);
    longint m;
    case (w[W-1:W-2])
      2'b00:   m = 0;
      2'b01:   m = (longint'(w[WE+WF-1:WF]) * longint'(1 << WF)) + longint'(w[WF-1:0]) + 1;
      default: m = longint'(1) <<< 40;
    endcase
    return w[W-3] ? -m : m;
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    exp_t e;
    longint va, vb;
    e = '0;
    if (a[W-1:W-2] == 2'b11 || b[W-1:W-2] == 2'b11) begin
      e.unord = 1'b1;
      e.mn = a;
      e.mx = a;
    end else begin
      va = ordinal(a);
      vb = ordinal(b);
      e.lt = (va < vb);
      e.eq = (va == vb);
      e.gt = (va > vb);
      e.mn = e.lt ? a : b;
      e.mx = e.lt ? b : a;
    end
    case (op)
      3'd0:    e.result = e.eq;
      3'd1:    e.result = !e.eq;
      3'd2:    e.result = e.lt;
      3'd3:    e.result = e.lt | e.eq;
      3'd4:    e.result = e.gt;
      3'd5:    e.result = e.gt | e.eq;
      default: e.result = 1'b0;
    endcase
    return e;
  endfunction

  // Scoreboard: every cycle a result is presented it must match the oldest
  // outstanding expectation (which also proves stability while stalled).
  always @(negedge clk) begin
    exp_t act;
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid) begin
        act = {out_result, out_lt, out_eq, out_gt, out_unord, out_min, out_max};
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: unexpected out_valid, actual=%h required none", act);
        end else begin
          if (act !== q[0]) begin
            errors++;
            $display("FAIL scoreboard: actual=%h required=%h", act, q[0]);
          end
          if (out_ready) begin
            void'(q.pop_front());
            out_count++;
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_op));
    end
  end

  // Random downstream readiness during the sweep
  always @(posedge clk) begin
    if (rnd_ready_en) begin
      #1;
      out_ready = ($urandom_range(3) != 0);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Present one pair; called at posedge+1, returns at posedge+1 after acceptance
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    int n;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready actual=0 required=1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL wait_out_timeout: out_valid actual=0 required=1");
    end
  endtask

  task automatic single(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    send(a, b, op);
    wait_out();
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] w;
    logic [10:0] e;
    logic [16:0] f;
    e = ($urandom_range(1) != 0) ? 11'(11'h3FF + 11'($urandom_range(2))) : 11'($urandom);
    f = ($urandom_range(1) != 0) ? 17'($urandom_range(3)) : 17'($urandom);
    w = {2'($urandom_range(3)), 1'($urandom_range(1)), e, f};
    return w;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ra, rb;
    int n;

    // Reset state
    #12;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_min", 64'(out_min), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic ordering with latency check
    in_a = ONE; in_b = TWO; in_op = 3'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("latency_cycle1_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("latency_cycle2_out_valid", 64'(out_valid), 64'd1);
    chk("lt_1_2_result", 64'(out_result), 64'd1);
    chk("lt_1_2_lt", 64'(out_lt), 64'd1);
    chk("lt_1_2_min", 64'(out_min), 64'(ONE));
    chk("lt_1_2_max", 64'(out_max), 64'(TWO));
    @(posedge clk); #1;

    single(ONE, TWO, 3'd5);
    chk("ge_1_2_result", 64'(out_result), 64'd0);
    @(posedge clk); #1;

    // Signed zero and negatives
    single(PZERO, NZERO, 3'd0);
    chk("pz_nz_eq", 64'(out_eq), 64'd1);
    chk("pz_nz_result", 64'(out_result), 64'd1);
    chk("pz_nz_min_is_b", 64'(out_min), 64'(NZERO));
    @(posedge clk); #1;
    single(MTWO, MONE, 3'd4);
    chk("m2_m1_gt_result", 64'(out_result), 64'd0);
    chk("m2_m1_lt", 64'(out_lt), 64'd1);
    @(posedge clk); #1;

    // NaN against every op
    for (int op = 0; op < 8; op++) begin
      single(QNAN, ONE, 3'(op));
      chk($sformatf("nan_op%0d_result", op), 64'(out_result), (op == 1) ? 64'd1 : 64'd0);
      chk($sformatf("nan_op%0d_unord", op), 64'(out_unord), 64'd1);
      chk($sformatf("nan_op%0d_max", op), 64'(out_max), 64'(QNAN));
      @(posedge clk); #1;
    end
    single(PINF, ONE, 3'd4);
    chk("inf_1_gt", 64'(out_gt), 64'd1);
    chk("inf_1_result", 64'(out_result), 64'd1);
    @(posedge clk); #1;

    // Backpressure: 8 pairs, out_ready low for cycles 3..7
    out_count = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send({2'b01, 1'(i & 1), 11'(11'h3F0 + 11'(i)), 17'h0}, ONE, 3'(i % 6));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        #1;
        chk("stall_in_ready_low", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        chk("stall_in_ready_still_low", 64'(in_ready), 64'd0);
        chk("stall_out_valid_held", 64'(out_valid), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    n = 0;
    while (q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    repeat (2) @(posedge clk);
    #1;
    chk("stall_result_count", 64'(out_count), 64'd8);

    // Reset with two pairs in flight
    out_ready = 1'b0;
    send(TWO, ONE, 3'd4);
    send(ONE, ONE, 3'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_result", 64'(out_result), 64'd0);
    chk("midrst_out_max", 64'(out_max), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    n = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    chk("midrst_no_stale", 64'(n), 64'd0);

    // Random sweep with random backpressure
    rnd_ready_en = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      ra = rnd_word();
      case ($urandom_range(3))
        0:       rb = ra;
        1:       rb = {ra[W-1:W-2], ~ra[W-3], ra[W-4:0]};
        default: rb = rnd_word();
      endcase
      send(ra, rb, 3'($urandom_range(7)));
    end
    rnd_ready_en = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
